// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and types for the 7-segment display path
package display_pkg;

    localparam int NUM_DIGITS_DEF = 8;
    localparam int SEG_W_DEF      = 8;

    typedef logic [SEG_W_DEF-1:0]                seg_t;
    typedef logic [NUM_DIGITS_DEF*SEG_W_DEF-1:0] frame_t;

    // Active-low segment codes, dp (bit7) off.
    localparam seg_t SEG_0     = 8'hC0;
    localparam seg_t SEG_1     = 8'hF9;
    localparam seg_t SEG_2     = 8'hA4;
    localparam seg_t SEG_3     = 8'hB0;
    localparam seg_t SEG_4     = 8'h99;
    localparam seg_t SEG_5     = 8'h92;
    localparam seg_t SEG_6     = 8'h82;
    localparam seg_t SEG_7     = 8'hF8;
    localparam seg_t SEG_8     = 8'h80;
    localparam seg_t SEG_9     = 8'h90;
    localparam seg_t SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational active-low 7-segment code to BCD nibble
//
// Ports:
//   i_seg     : segment byte (bit7 = dp, ignored)
//   o_bcd     : decoded digit 0..9, 4'hF when unrecognised
//   o_invalid : high when the code is not a decimal digit
module seg7_to_bcd
    import display_pkg::*;
(
    input  seg_t       i_seg,
    output logic [3:0] o_bcd,
    output logic       o_invalid
);

    seg_t w_code;

    // Force dp off so a lit decimal point does not change the digit.
    assign w_code = i_seg | 8'h80;

    always_comb begin
        o_bcd     = 4'hF;
        o_invalid = 1'b0;
        case (w_code)
            SEG_0:   o_bcd = 4'd0;
            SEG_1:   o_bcd = 4'd1;
            SEG_2:   o_bcd = 4'd2;
            SEG_3:   o_bcd = 4'd3;
            SEG_4:   o_bcd = 4'd4;
            SEG_5:   o_bcd = 4'd5;
            SEG_6:   o_bcd = 4'd6;
            SEG_7:   o_bcd = 4'd7;
            SEG_8:   o_bcd = 4'd8;
            SEG_9:   o_bcd = 4'd9;
            default: o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/scan_frame_capture.sv
// rtl/scan_frame_capture.sv - rebuilds a full segment frame from a multiplexed 7-segment scan bus
//
// Optional feature macro: SEG_DECODE_EN (adds frame_bcd / decode_err).
//
// Ports:
//   CP_1KHz      : clock, rising edge
//   _CR          : synchronous active-low reset
//   select_light : active-low digit select
//   display_char : segment code of the selected digit
//   frame_data   : last completed frame, digit i at [SEG_W*i +: SEG_W]
//   frame_valid  : one-cycle pulse when frame_data updates
//   frame_stable : last STABLE_FRAMES completed frames identical
//   digit_mask   : digits captured in the frame in progress
//   scan_err     : one-cycle pulse per dwell on a multi-digit select
//   frame_bcd    : (SEG_DECODE_EN) decoded digits of the last frame
//   decode_err   : (SEG_DECODE_EN) pulse when a completed frame has a non-digit code
module scan_frame_capture
    import display_pkg::*;
#(
    parameter int NUM_DIGITS    = NUM_DIGITS_DEF,
    parameter int SEG_W         = SEG_W_DEF,
    parameter int SETTLE        = 0,
    parameter int STABLE_FRAMES = 2
)
(
    input  logic                        CP_1KHz,
    input  logic                        _CR,
    input  logic [NUM_DIGITS-1:0]       select_light,
    input  logic [SEG_W-1:0]            display_char,
    output logic [NUM_DIGITS*SEG_W-1:0] frame_data,
    output logic                        frame_valid,
    output logic                        frame_stable,
    output logic [NUM_DIGITS-1:0]       digit_mask,
    output logic                        scan_err
`ifdef SEG_DECODE_EN
    ,
    output logic [NUM_DIGITS*4-1:0]     frame_bcd,
    output logic                        decode_err
`endif
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = $clog2(SETTLE + 2);
    localparam logic [DW-1:0] DWELL_CAP  = DW'(SETTLE);
    localparam logic [DW-1:0] DWELL_MAX  = DW'(SETTLE + 1);
    localparam logic [3:0]    STABLE_MAX = 4'(STABLE_FRAMES - 1);

    logic [NUM_DIGITS-1:0]                r_sel, r_sel_d;
    logic [SEG_W-1:0]                     r_char, r_char_d;
    logic [DW-1:0]                        r_dwell;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]     r_shadow;
    logic [NUM_DIGITS-1:0]                r_mask;
    logic [NUM_DIGITS*SEG_W-1:0]          r_frame;
    logic                                 r_valid;
    logic                                 r_stable;
    logic [3:0]                           r_stable_cnt;
    logic                                 r_err;

    logic                                 w_found, w_multi;
    logic [IDX_W-1:0]                     w_idx;
    logic                                 w_changed;
    logic [DW-1:0]                        w_dwell;
    logic                                 w_dwell_hit;
    logic                                 w_capture, w_illegal, w_complete;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]     w_shadow_next;
    logic [NUM_DIGITS-1:0]                w_mask_next;
    logic [NUM_DIGITS*SEG_W-1:0]          w_new_frame;
    logic [3:0]                           w_stable_cnt_next;

    // Locate the low select bit and flag when more than one is low.
    always_comb begin
        w_found = 1'b0;
        w_multi = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_sel[i]) begin
                if (w_found) begin
                    w_multi = 1'b1;
                end
                w_found = 1'b1;
                w_idx   = IDX_W'(i);
            end
        end
    end

    // Dwell count for the current registered pair; saturating one past the
    // capture point guarantees a single capture however long the dwell.
    assign w_changed = (r_sel != r_sel_d) || (r_char != r_char_d);

    always_comb begin
        w_dwell = r_dwell;
        if (w_changed) begin
            w_dwell = '0;
        end else if (r_dwell != DWELL_MAX) begin
            w_dwell = r_dwell + 1'b1;
        end
    end

    assign w_dwell_hit = (w_dwell == DWELL_CAP);
    assign w_capture   = w_dwell_hit & w_found & ~w_multi;
    assign w_illegal   = w_dwell_hit & w_multi;

    always_comb begin
        w_shadow_next        = r_shadow;
        w_mask_next          = r_mask;
        w_shadow_next[w_idx] = r_char;
        w_mask_next[w_idx]   = 1'b1;
    end

    assign w_complete  = w_capture & (&w_mask_next);
    assign w_new_frame = w_shadow_next;

    always_comb begin
        w_stable_cnt_next = 4'd0;
        if (w_new_frame == r_frame) begin
            w_stable_cnt_next = (r_stable_cnt == STABLE_MAX) ? r_stable_cnt
                                                             : r_stable_cnt + 4'd1;
        end
    end

    always_ff @(posedge CP_1KHz) begin
        if (!_CR) begin
            r_sel        <= '1;
            r_char       <= '1;
            r_sel_d      <= '1;
            r_char_d     <= '1;
            r_dwell      <= '0;
            r_shadow     <= '1;
            r_mask       <= '0;
            r_frame      <= '1;
            r_valid      <= 1'b0;
            r_stable     <= 1'b0;
            r_stable_cnt <= 4'd0;
            r_err        <= 1'b0;
        end else begin
            r_sel    <= select_light;
            r_char   <= display_char;
            r_sel_d  <= r_sel;
            r_char_d <= r_char;
            r_dwell  <= w_dwell;
            r_valid  <= 1'b0;
            r_err    <= w_illegal;
            if (w_capture) begin
                r_shadow <= w_shadow_next;
                if (w_complete) begin
                    r_mask       <= '0;
                    r_frame      <= w_new_frame;
                    r_valid      <= 1'b1;
                    r_stable_cnt <= w_stable_cnt_next;
                    r_stable     <= (w_stable_cnt_next == STABLE_MAX);
                end else begin
                    r_mask <= w_mask_next;
                end
            end
        end
    end

    assign frame_data   = r_frame;
    assign frame_valid  = r_valid;
    assign frame_stable = r_stable;
    assign digit_mask   = r_mask;
    assign scan_err     = r_err;

`ifdef SEG_DECODE_EN
    logic [NUM_DIGITS*4-1:0] w_bcd;
    logic [NUM_DIGITS-1:0]   w_bad;
    logic [NUM_DIGITS*4-1:0] r_bcd;
    logic                    r_dec_err;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_to_bcd u_dec (
            .i_seg     (w_shadow_next[g]),
            .o_bcd     (w_bcd[g*4 +: 4]),
            .o_invalid (w_bad[g])
        );
    end

    always_ff @(posedge CP_1KHz) begin
        if (!_CR) begin
            r_bcd     <= '1;
            r_dec_err <= 1'b0;
        end else begin
            r_dec_err <= 1'b0;
            if (w_complete) begin
                r_bcd     <= w_bcd;
                r_dec_err <= |w_bad;
            end
        end
    end

    assign frame_bcd  = r_bcd;
    assign decode_err = r_dec_err;
`endif

endmodule
